pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three sources: load-use hazards, branches taken in ID, and multi-cycle data-memory accesses.
- Owns a wait-state FSM with a timeout watchdog; sits beside the hazard/forwarding logic in the top-level CPU.

Parameters:
WAIT_MAX, 64, max consecutive MEM_WAIT cycles before the fatal error; legal range 2..255.
CNT_W, 8, width of the wait counter; must hold WAIT_MAX.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_Rt_i  in  5  load destination register in EX
IFID_Rs_i  in  5  source register Rs of the instruction in ID
IFID_Rt_i  in  5  source register Rt of the instruction in ID
Branch_taken_i  in  1  branch resolved taken in ID
MemAccess_i  in  1  EX/MEM holds a load or store
MemReady_i  in  1  data memory completes the access this cycle
PCWrite_o  out  1  PC update enable
IFIDWrite_o  out  1  IF/ID load enable
IFIDFlush_o  out  1  IF/ID cleared to NOP
IDEXWrite_o  out  1  ID/EX load enable
IDEXBubble_o  out  1  ID/EX control bits zeroed
EXMEMWrite_o  out  1  EX/MEM load enable
MEMWBBubble_o  out  1  MEM/WB WB bits (RegWrite, MemtoReg) zeroed
Err_o  out  1  sticky watchdog error

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Outputs are Mealy: a function of state and current inputs.
- Reset (rst_i=0, async):
  - State goes to RUN, wait counter goes to 0, Err_o=0.
  - While reset is held: all *Write_o=0, IFIDFlush_o=1, IDEXBubble_o=1, MEMWBBubble_o=1.
- luse = IDEX_MemRead_i & (IDEX_Rt_i!=0) & (IDEX_Rt_i==IFID_Rs_i | IDEX_Rt_i==IFID_Rt_i).
- memstall = MemAccess_i & ~MemReady_i.
- Default in RUN: all writes 1, flush/bubbles 0.
- Priority in RUN, highest first:
  1. memstall: PC/IFID/IDEX/EXMEM writes 0, MEMWBBubble_o=1. Next state MEM_WAIT, counter=1.
  2. luse: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1. Exactly one stall cycle. Branch_taken_i is ignored this cycle because the branch re-resolves next cycle.
  3. Branch_taken_i: IFIDFlush_o=1. Exactly one flush cycle; PC loads the target normally.
- MEM_WAIT:
  - If MemReady_i=1: outputs as in RUN with memstall=0 (luse and branch evaluated normally), next state RUN, counter cleared.
  - Otherwise: freeze outputs as in item 1 above, counter increments.
  - If the counter equals WAIT_MAX and MemReady_i=0: next state ERR.
  - MemReady_i arriving on the same cycle the counter equals WAIT_MAX counts as success; no error.
- ERR:
  - All writes 0, all bubbles/flush 1, Err_o=1.
  - Exits only on reset.
- Counter never wraps; it saturates at WAIT_MAX.
- Reset asserted mid-MEM_WAIT abandons the access immediately; no stale freeze after release.
- A second memstall immediately after returning to RUN re-enters MEM_WAIT with counter=1.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - Adds ports StallCnt_o (out, 32) and FlushCnt_o (out, 32), both reset to 0.
  - StallCnt_o increments on every cycle with PCWrite_o=0 outside reset.
  - FlushCnt_o increments on every cycle with IFIDFlush_o=1 outside reset.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state typedef {RUN, MEM_WAIT, ERR};
  - REG_ZERO=5'd0;
  - default WAIT_MAX.
- One natural combinational sub-module, load_use_detect: it computes luse from the IDEX/IFID fields and is instanced once.

Test Plan:
- Load-use: IDEX_MemRead_i=1, IDEX_Rt_i=5, IFID_Rs_i=5 -> one cycle of PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1, then normal outputs. Repeat with IDEX_Rt_i=0 -> no stall.
- Branch flush: Branch_taken_i=1 with no hazard -> IFIDFlush_o=1 for exactly one cycle. Branch_taken_i=1 together with luse -> IFIDFlush_o=0, IDEXBubble_o=1.
- Memory wait: MemAccess_i=1, MemReady_i=0 for 3 cycles, then 1 -> 3 frozen cycles with MEMWBBubble_o=1; RUN outputs on the ready cycle; state back to RUN.
- Watchdog: WAIT_MAX=4, MemReady_i held 0 -> Err_o=1 after the fourth wait cycle and stays 1. Same test with MemReady_i=1 on the boundary cycle -> Err_o stays 0.
- Reset mid-wait: drop rst_i during MEM_WAIT -> all writes 0 asynchronously; after release, state RUN, Err_o=0, counter 0.
- PIPE_CTRL_PERF_EN build: 1 load-use stall plus 3 memory-wait cycles plus 2 branch flushes -> StallCnt_o=4, FlushCnt_o=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         WAIT_MAX_DEF = 64;
  localparam int         CNT_W_DEF    = 8;

  // One bundle of every pipeline-register control the sequencer drives.
  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexWrite;
    logic idexBubble;
    logic exmemWrite;
    logic memwbBubble;
  } ctrl_t;

  // Whole pipeline held, nothing written, every stage neutralised.
  localparam ctrl_t CTRL_KILL = '{
    pcWrite:     1'b0,
    ifidWrite:   1'b0,
    ifidFlush:   1'b1,
    idexWrite:   1'b0,
    idexBubble:  1'b1,
    exmemWrite:  1'b0,
    memwbBubble: 1'b1
  };

  // Memory stall: everything up to EX/MEM frozen, a bubble drains into WB.
  localparam ctrl_t CTRL_FREEZE = '{
    pcWrite:     1'b0,
    ifidWrite:   1'b0,
    ifidFlush:   1'b0,
    idexWrite:   1'b0,
    idexBubble:  1'b0,
    exmemWrite:  1'b0,
    memwbBubble: 1'b1
  };

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Load-use hazard detector: load in EX writes a register the ID instruction reads.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       memRead,
  input  logic [4:0] exRt,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  output logic       luse
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign luse = memRead && (exRt != REG_ZERO) && ((exRt == idRs) || (exRt == idRt));

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with memory wait-state watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_Rt_i,
  input  logic [4:0]  IFID_Rs_i,
  input  logic [4:0]  IFID_Rt_i,
  input  logic        Branch_taken_i,
  input  logic        MemAccess_i,
  input  logic        MemReady_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IFIDFlush_o,
  output logic        IDEXWrite_o,
  output logic        IDEXBubble_o,
  output logic        EXMEMWrite_o,
  output logic        MEMWBBubble_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] StallCnt_o,
  output logic [31:0] FlushCnt_o,
`endif
  output logic        Err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitCntNext;
  logic             luse;
  logic             memStall;
  ctrl_t            ctrl;

  function automatic logic [CNT_W-1:0] satIncCnt(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  // Normal-flow controls: a load-use stall outranks a taken branch, because
  // the branch re-resolves once the stalled instruction reissues from ID.
  function automatic ctrl_t runCtrl(input logic hazard, input logic branch);
    ctrl_t c;
    c.pcWrite     = ~hazard;
    c.ifidWrite   = ~hazard;
    c.ifidFlush   = branch & ~hazard;
    c.idexWrite   = 1'b1;
    c.idexBubble  = hazard;
    c.exmemWrite  = 1'b1;
    c.memwbBubble = 1'b0;
    return c;
  endfunction

  load_use_detect uLud (
    .memRead (IDEX_MemRead_i),
    .exRt    (IDEX_Rt_i),
    .idRs    (IFID_Rs_i),
    .idRt    (IFID_Rt_i),
    .luse    (luse)
  );

  assign memStall = MemAccess_i & ~MemReady_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    ctrl        = runCtrl(luse, Branch_taken_i);
    case (state)
      RUN: begin
        if (memStall) begin
          ctrl        = CTRL_FREEZE;
          stateNext   = MEM_WAIT;
          waitCntNext = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        // Ready on the limit cycle still completes the access.
        if (MemReady_i) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else begin
          ctrl        = CTRL_FREEZE;
          waitCntNext = satIncCnt(waitCnt);
          if (waitCnt == CNT_MAX) stateNext = ERR;
        end
      end
      ERR: begin
        ctrl = CTRL_KILL;
      end
      default: begin
        ctrl      = CTRL_KILL;
        stateNext = ERR;
      end
    endcase
    // Reset must quiesce the pipeline immediately, not at the next edge.
    if (!rst_i) ctrl = CTRL_KILL;
  end

  assign PCWrite_o     = ctrl.pcWrite;
  assign IFIDWrite_o   = ctrl.ifidWrite;
  assign IFIDFlush_o   = ctrl.ifidFlush;
  assign IDEXWrite_o   = ctrl.idexWrite;
  assign IDEXBubble_o  = ctrl.idexBubble;
  assign EXMEMWrite_o  = ctrl.exmemWrite;
  assign MEMWBBubble_o = ctrl.memwbBubble;
  assign Err_o         = (state == ERR);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!ctrl.pcWrite)  stallCnt <= satInc32(stallCnt);
      if (ctrl.ifidFlush) flushCnt <= satInc32(flushCnt);
    end
  end

  assign StallCnt_o = stallCnt;
  assign FlushCnt_o = flushCnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table, hand sequences and random traffic vs a reference model.
module tb_pipe_ctrl;

  localparam int WMAX = 4;

  // Packed as {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMWrite, MEMWBBubble, Err}
  localparam logic [7:0] NORM = 8'b1101_0100;
  localparam logic [7:0] LUSE = 8'b0001_1100;
  localparam logic [7:0] BRF  = 8'b1111_0100;
  localparam logic [7:0] FRZ  = 8'b0000_0010;
  localparam logic [7:0] DEAD = 8'b0010_1011;
  localparam logic [7:0] RSTV = 8'b0010_1010;

  logic       clk = 1'b0;
  logic       rstN;
  logic       memRead, br, acc, rdy;
  logic [4:0] exRt, idRs, idRt;
  logic       pcW, ifidW, ifidF, idexW, idexB, exmemW, memwbB, err;
  logic [7:0] outs;
  int         nCmp = 0;
  int         nFail = 0;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCntO, flushCntO;
`endif

  pipe_ctrl #(.WAIT_MAX(WMAX), .CNT_W(8)) dut (
    .clk_i          (clk),
    .rst_i          (rstN),
    .IDEX_MemRead_i (memRead),
    .IDEX_Rt_i      (exRt),
    .IFID_Rs_i      (idRs),
    .IFID_Rt_i      (idRt),
    .Branch_taken_i (br),
    .MemAccess_i    (acc),
    .MemReady_i     (rdy),
    .PCWrite_o      (pcW),
    .IFIDWrite_o    (ifidW),
    .IFIDFlush_o    (ifidF),
    .IDEXWrite_o    (idexW),
    .IDEXBubble_o   (idexB),
    .EXMEMWrite_o   (exmemW),
    .MEMWBBubble_o  (memwbB),
`ifdef PIPE_CTRL_PERF_EN
    .StallCnt_o     (stallCntO),
    .FlushCnt_o     (flushCntO),
`endif
    .Err_o          (err)
  );

  assign outs = {pcW, ifidW, ifidF, idexW, idexB, exmemW, memwbB, err};

  always #5 clk = ~clk;

  // Reference model: "streak" is the run of consecutive cycles the pipeline
  // has been frozen on an unfinished memory access; more than WMAX is fatal.
  int          streak;
  bit          dead;
  logic [31:0] mStall, mFlush;
  logic [7:0]  mExp;

  function automatic logic [7:0] modelOut(input logic rn, input bit dd, input int st,
                                          input logic r, input logic a, input logic mr,
                                          input logic [4:0] xr, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic b);
    bit hz;
    hz = mr && (xr != 0) && (xr == rs || xr == rt);
    if (!rn) return RSTV;
    if (dd) return DEAD;
    if (!r && (st > 0 || a)) return FRZ;
    if (hz) return LUSE;
    if (b) return BRF;
    return NORM;
  endfunction

  assign mExp = modelOut(rstN, dead, streak, rdy, acc, memRead, exRt, idRs, idRt, br);

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      streak <= 0;
      dead   <= 1'b0;
      mStall <= '0;
      mFlush <= '0;
    end else begin
      if (!mExp[7] && mStall != 32'hFFFF_FFFF) mStall <= mStall + 32'd1;
      if (mExp[5] && mFlush != 32'hFFFF_FFFF) mFlush <= mFlush + 32'd1;
      if (!dead) begin
        if (!rdy && (streak > 0 || acc)) begin
          streak <= streak + 1;
          if (streak + 1 > WMAX) dead <= 1'b1;
        end else begin
          streak <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    nCmp++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    nCmp++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic checkModel(input string name);
    check({name, "_model"}, outs, mExp);
`ifdef PIPE_CTRL_PERF_EN
    check32({name, "_stallcnt"}, stallCntO, mStall);
    check32({name, "_flushcnt"}, flushCntO, mFlush);
`endif
  endtask

  task automatic checkBoth(input string name, input logic [7:0] want);
    check(name, outs, want);
    checkModel(name);
  endtask

  task automatic apply(input logic mr, input logic [4:0] xr, input logic [4:0] rs,
                       input logic [4:0] rt, input logic b, input logic a, input logic r);
    @(negedge clk);
    memRead = mr; exRt = xr; idRs = rs; idRt = rt; br = b; acc = a; rdy = r;
    #2;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    memRead = 0; exRt = 0; idRs = 0; idRt = 0; br = 0; acc = 0; rdy = 0;
    #2 checkBoth("rst_hold", RSTV);
    @(negedge clk);
    rstN = 1'b1;
    #2 checkBoth("rst_release", NORM);
  endtask

  typedef struct {
    logic       mr;
    logic [4:0] xr, rs, rt;
    logic       b, a, r;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM};
    tbl[1] = '{1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, LUSE};
    tbl[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM};
    tbl[3] = '{1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1, LUSE};
    tbl[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, NORM};
    tbl[5] = '{1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, BRF};
    tbl[6] = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, LUSE};
    tbl[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, BRF};
    tbl[8] = '{1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0, NORM};
    tbl[9] = '{1'b1, 5'd31, 5'd31, 5'd1, 1'b0, 1'b1, 1'b1, LUSE};

    rstN = 1'b0;
    memRead = 0; exRt = 0; idRs = 0; idRt = 0; br = 0; acc = 0; rdy = 0;
    repeat (2) @(negedge clk);
    #2 checkBoth("reset_state", RSTV);
    @(negedge clk);
    rstN = 1'b1;
    #2 checkBoth("first_run", NORM);

    // 1 load-use stall, 3 frozen memory cycles, 2 branch flushes
    apply(1, 5'd5, 5'd5, 5'd0, 0, 0, 0); checkBoth("luse_stall", LUSE);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 0, 0); checkBoth("luse_after", NORM);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); checkBoth("mw_frz1", FRZ);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); checkBoth("mw_frz2", FRZ);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); checkBoth("mw_frz3", FRZ);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 1); checkBoth("mw_ready", NORM);
    apply(0, 5'd0, 5'd0, 5'd0, 1, 0, 0); checkBoth("br_flush1", BRF);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 0, 0); checkBoth("br_once1", NORM);
    apply(0, 5'd0, 5'd0, 5'd0, 1, 0, 0); checkBoth("br_flush2", BRF);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 0, 0); checkBoth("br_once2", NORM);
`ifdef PIPE_CTRL_PERF_EN
    check32("perf_stall_total", stallCntO, 32'd4);
    check32("perf_flush_total", flushCntO, 32'd2);
`endif

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].mr, tbl[i].xr, tbl[i].rs, tbl[i].rt, tbl[i].b, tbl[i].a, tbl[i].r);
      checkBoth($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Re-entry into the wait right after a completed access, ready with load-use
    apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); checkBoth("re_frz", FRZ);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 1); checkBoth("re_ready", NORM);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); checkBoth("re_again", FRZ);
    apply(1, 5'd6, 5'd6, 5'd0, 1, 1, 1); checkBoth("re_ready_luse", LUSE);

    // Watchdog: five frozen cycles (RUN entry + WMAX waits) then fatal
    for (int i = 0; i < WMAX + 1; i++) begin
      apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); checkBoth("wd_frz", FRZ);
    end
    apply(0, 5'd0, 5'd0, 5'd0, 0, 0, 1); checkBoth("wd_err", DEAD);
    apply(1, 5'd2, 5'd2, 5'd0, 1, 1, 1); checkBoth("wd_sticky1", DEAD);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 0, 0); checkBoth("wd_sticky2", DEAD);
    doReset();

    // Ready on the limit cycle completes without error
    for (int i = 0; i < WMAX; i++) begin
      apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); checkBoth("bd_frz", FRZ);
    end
    apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 1); checkBoth("bd_ready", NORM);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 0, 0); checkBoth("bd_noerr", NORM);

    // Reset dropped mid-wait, between clock edges
    apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); checkBoth("mr_frz1", FRZ);
    apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); checkBoth("mr_frz2", FRZ);
    #1 rstN = 1'b0;
    #1 checkBoth("mr_async", RSTV);
    @(negedge clk);
    rstN = 1'b1; acc = 0; rdy = 0;
    #2 checkBoth("mr_no_stale", NORM);
    for (int i = 0; i < WMAX + 1; i++) begin
      apply(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); checkBoth("mr_cnt_fresh", FRZ);
    end
    apply(0, 5'd0, 5'd0, 5'd0, 0, 0, 0); checkBoth("mr_err", DEAD);
    doReset();

    // Random traffic against the model, with stuck-memory windows and reset pulses
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rstN    = ($urandom_range(0, 59) != 0);
      memRead = 1'($urandom_range(0, 1));
      exRt    = 5'($urandom_range(0, 3));
      idRs    = 5'($urandom_range(0, 3));
      idRt    = 5'($urandom_range(0, 3));
      br      = ($urandom_range(0, 3) == 0);
      acc     = ($urandom_range(0, 2) == 0);
      rdy     = ((i % 80) < 10) ? 1'b0 : ($urandom_range(0, 2) != 0);
      #2 checkModel("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
